// File: rtl/fpu_arbiter.sv
// Two-client arbiter/sequencer for the shared multi-cycle FPU adder.
// Define FPU_ARB_RR_EN for round-robin tie-breaking; otherwise client 0 wins ties.
module fpu_arbiter #(
    parameter int WAIT_CYCLES = 72
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] op_a0,
    input  logic [31:0] op_b0,
    input  logic [31:0] op_a1,
    input  logic [31:0] op_b1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] result,
    output logic [3:0]  status,
    output logic        busy,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    output logic        fpu_reset_n,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status
);

    localparam int CNT_W = $clog2(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               owner;
    logic               grant;
    logic               grant_sel;

    assign grant = req0 | req1;

`ifdef FPU_ARB_RR_EN
    logic ptr;

    // On a tie the pointer names the preferred client.
    always_comb begin
        grant_sel = !req0;
        if (req0 && req1)
            grant_sel = ptr;
    end

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset)
            ptr <= 1'b0;
        else if (state == CAPTURE)
            ptr <= ~owner;
    end
`else
    always_comb begin
        grant_sel = !req0;
    end
`endif

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            result      <= '0;
            status      <= '0;
            busy        <= 1'b0;
            fpu_op_a    <= '0;
            fpu_op_b    <= '0;
            fpu_reset_n <= 1'b0;
            cnt         <= '0;
            owner       <= 1'b0;
        end else begin
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner    <= grant_sel;
                        ack0     <= !grant_sel;
                        ack1     <= grant_sel;
                        busy     <= 1'b1;
                        fpu_op_a <= grant_sel ? op_a1 : op_a0;
                        fpu_op_b <= grant_sel ? op_b1 : op_b0;
                    end
                end
                LAUNCH: begin
                    fpu_reset_n <= 1'b1;
                    cnt         <= CNT_W'(WAIT_CYCLES - 1);
                end
                WAIT: begin
                    // The FPU free-runs; only a later pass is trusted, so the full budget elapses.
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                end
                CAPTURE: begin
                    result      <= fpu_data;
                    status      <= fpu_status;
                    done0       <= !owner;
                    done1       <= owner;
                    busy        <= 1'b0;
                    fpu_reset_n <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: vector table plus directed tie, busy, reset and stability sequences.
// A small FPU stand-in returns garbage for its first pass after reset, then the correct sum.
module tb_fpu_arbiter;

    localparam int W = 72;

    logic        clock100KHz = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [31:0] op_a0 = '0;
    logic [31:0] op_b0 = '0;
    logic [31:0] op_a1 = '0;
    logic [31:0] op_b1 = '0;
    logic        ack0, ack1, done0, done1, busy, fpu_reset_n;
    logic [31:0] result, fpu_op_a, fpu_op_b, fpu_data;
    logic [3:0]  status, fpu_status;

    int n_cmp = 0;
    int n_err = 0;

    fpu_arbiter #(.WAIT_CYCLES(W)) dut (
        .clock100KHz(clock100KHz), .reset(reset),
        .req0(req0), .req1(req1),
        .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .status(status), .busy(busy),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_reset_n(fpu_reset_n),
        .fpu_data(fpu_data), .fpu_status(fpu_status)
    );

    always #5 clock100KHz = ~clock100KHz;

    // FPU stand-in: equal magnitudes add exactly (double or cancel), anything else reports overflow.
    function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == b[30:0]) begin
            if (a[31] == b[31])
                return {4'b0001, a[31], a[30:25] + 6'd1, a[24:0]};
            return {4'b0001, 32'h0000_0000};
        end
        return {4'b0100, 32'h7FFF_FFFF};
    endfunction

    int          fpu_cnt;
    logic [35:0] fpu_pass;

    always @(posedge clock100KHz or negedge fpu_reset_n) begin
        if (!fpu_reset_n)
            fpu_cnt <= 0;
        else if (fpu_cnt < 1000)
            fpu_cnt <= fpu_cnt + 1;
    end

    assign fpu_pass   = fpu_model(fpu_op_a, fpu_op_b);
    assign fpu_data   = (fpu_cnt >= 34) ? fpu_pass[31:0]  : 32'hBAD0_0000;
    assign fpu_status = (fpu_cnt >= 34) ? fpu_pass[35:32] : 4'b1000;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        int          exp_client;
        logic [31:0] exp_result;
        logic [3:0]  exp_status;
    } vec_t;

    vec_t vecs[4];
    int   tie_exp[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (3) @(negedge clock100KHz);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int limit, output int client, output int waited);
        client = -1;
        waited = 0;
        while (client < 0 && waited < limit) begin
            @(negedge clock100KHz);
            waited++;
            if (ack0 || ack1)
                client = ack1 ? 1 : 0;
        end
        check({tag, " ack seen"}, 32'(client >= 0), 32'd1);
    endtask

    // Follows one operation from the ack's sample point to its done pulse.
    task automatic wait_done(input string tag, input int exp_client, input logic [31:0] exp_res,
                             input logic [3:0] exp_st, input logic [31:0] exp_a,
                             input logic [31:0] exp_b, input int raise1_at);
        int lat = 0;
        int stray = 0;
        int opchg = 0;
        logic got = 1'b0;
        while (!got && lat < W + 10) begin
            @(negedge clock100KHz);
            lat++;
            if (lat == 1)
                check({tag, " fpu_reset_n released"}, 32'(fpu_reset_n), 32'd1);
            if (lat == raise1_at)
                req1 = 1'b1;
            if (ack0 || ack1)
                stray++;
            if (fpu_op_a !== exp_a || fpu_op_b !== exp_b)
                opchg++;
            if (done0 || done1)
                got = 1'b1;
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " done client"}, 32'({done1, done0}), (exp_client == 1) ? 32'd2 : 32'd1);
            check({tag, " done latency"}, 32'(lat), 32'(W + 2));
            check({tag, " result"}, result, exp_res);
            check({tag, " status"}, 32'(status), 32'(exp_st));
            check({tag, " busy/fpu_reset_n at done"}, 32'({busy, fpu_reset_n}), 32'd0);
        end
        check({tag, " acks during op"}, 32'(stray), 32'd0);
        check({tag, " fpu operands stable"}, 32'(opchg), 32'd0);
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int client;
        int waited;
        @(negedge clock100KHz);
        op_a0 = v.a0;
        op_b0 = v.b0;
        op_a1 = v.a1;
        op_b1 = v.b1;
        req0  = v.r0;
        req1  = v.r1;
        wait_ack(tag, 8, client, waited);
        if (client >= 0) begin
            check({tag, " ack onehot"}, 32'({ack1, ack0}), (v.exp_client == 1) ? 32'd2 : 32'd1);
            check({tag, " ack latency"}, 32'(waited), 32'd1);
            check({tag, " busy/fpu_reset_n at ack"}, 32'({busy, fpu_reset_n}), 32'd2);
            req0 = 1'b0;
            req1 = 1'b0;
            wait_done(tag, v.exp_client, v.exp_result, v.exp_status,
                      (v.exp_client == 1) ? v.a1 : v.a0,
                      (v.exp_client == 1) ? v.b1 : v.b0, -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int client;
        int waited;
        int dones;

        vecs[0] = '{1'b1, 1'b0, 32'h0200_0000, 32'h0200_0000, 32'h0, 32'h0, 0, 32'h0400_0000, 4'b0001};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h0200_0000, 32'h8200_0000, 1, 32'h0000_0000, 4'b0001};
        vecs[2] = '{1'b1, 1'b0, 32'h8300_0000, 32'h8300_0000, 32'h0, 32'h0, 0, 32'h8500_0000, 4'b0001};
        vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_0000, 1, 32'h7FFF_FFFF, 4'b0100};
`ifdef FPU_ARB_RR_EN
        tie_exp = '{0, 1, 0};
`else
        tie_exp = '{0, 0, 0};
`endif

        // Reset state
        do_reset();
        @(negedge clock100KHz);
        check("reset ctrl {ack,done,busy,fpu_reset_n}",
              32'({ack0, ack1, done0, done1, busy, fpu_reset_n}), 32'd0);
        check("reset result", result, 32'd0);
        check("reset status", 32'(status), 32'd0);
        check("reset fpu_op_a", fpu_op_a, 32'd0);
        check("reset fpu_op_b", fpu_op_b, 32'd0);

        // Table-driven single operations
        for (int i = 0; i < 4; i++)
            run_op($sformatf("vec%0d", i), vecs[i]);

        // Reset 20 cycles into WAIT: everything clears at once and no done follows
        @(negedge clock100KHz);
        op_a0 = 32'h0200_0000;
        op_b0 = 32'h0200_0000;
        req0  = 1'b1;
        wait_ack("rst_mid", 8, client, waited);
        req0 = 1'b0;
        repeat (21) @(negedge clock100KHz);
        #2 reset = 1'b1;
        #1;
        check("rst_mid ctrl cleared", 32'({ack0, ack1, done0, done1, busy, fpu_reset_n}), 32'd0);
        check("rst_mid result cleared", result, 32'd0);
        check("rst_mid status cleared", 32'(status), 32'd0);
        check("rst_mid fpu_op cleared", fpu_op_a | fpu_op_b, 32'd0);
        repeat (2) @(negedge clock100KHz);
        reset = 1'b0;
        dones = 0;
        repeat (W + 10) begin
            @(negedge clock100KHz);
            if (done0 || done1)
                dones++;
        end
        check("rst_mid no done", 32'(dones), 32'd0);
        run_op("rst_mid rerun", vecs[0]);

        // Tie with both requests held across three rounds
        do_reset();
        @(negedge clock100KHz);
        op_a0 = 32'h0200_0000;
        op_b0 = 32'h0200_0000;
        op_a1 = 32'h0200_0000;
        op_b1 = 32'h8200_0000;
        req0  = 1'b1;
        req1  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_ack($sformatf("tie%0d", r), W + 10, client, waited);
            check($sformatf("tie%0d winner", r), 32'(client), 32'(tie_exp[r]));
            check($sformatf("tie%0d ack gap", r), 32'(waited), 32'd1);
            check($sformatf("tie%0d single ack", r), 32'(ack0 & ack1), 32'd0);
            if (r == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            wait_done($sformatf("tie%0d", r), tie_exp[r],
                      (tie_exp[r] == 1) ? 32'h0000_0000 : 32'h0400_0000, 4'b0001,
                      32'h0200_0000, (tie_exp[r] == 1) ? 32'h8200_0000 : 32'h0200_0000, -1);
        end

        // req1 raised mid-WAIT of client 0, and op_a0 changed after ack0
        @(negedge clock100KHz);
        op_a0 = 32'h0200_0000;
        op_b0 = 32'h0200_0000;
        op_a1 = 32'h0200_0000;
        op_b1 = 32'h8200_0000;
        req0  = 1'b1;
        wait_ack("busy c0", 8, client, waited);
        check("busy c0 winner", 32'(client), 32'd0);
        req0  = 1'b0;
        op_a0 = 32'h0600_0000;
        wait_done("busy c0", 0, 32'h0400_0000, 4'b0001, 32'h0200_0000, 32'h0200_0000, 20);
        wait_ack("busy c1", 1, client, waited);
        check("busy c1 winner", 32'(client), 32'd1);
        req1 = 1'b0;
        wait_done("busy c1", 1, 32'h0000_0000, 4'b0001, 32'h0200_0000, 32'h8200_0000, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Two-client arbiter and sequencer for the shared multi-cycle FPU adder. It accepts operand pairs from two requesters, grants one at a time, drives the FPU's operand inputs and active-low reset, and waits a fixed cycle budget. It then captures `data_out`/`status_out` and returns the result to the owning client with a one-cycle done pulse.

## Interface
- `WAIT_CYCLES`, default 72: cycles budgeted per operation; must be ≥ 66 (two worst-case FPU passes plus margin).
- `clock100KHz`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  request level; the requester holds it with its operands stable until the matching ack.
- `op_a0`, `op_b0`, `op_a1`, `op_b1`  in  32  operand pairs, in FPU format: sign, 6-bit exponent, 25-bit mantissa.
- `ack0`, `ack1`  out  1  one-cycle pulse; the request and its operands were accepted.
- `done0`, `done1`  out  1  one-cycle pulse; `result`/`status` are valid for that client.
- `result`  out  32  captured FPU `data_out`; held until the next capture.
- `status`  out  4  captured FPU `status_out` (0001 exact, 0010 inexact, 0100 overflow, 1000 underflow).
- `busy`  out  1  high while an operation is in flight.
- `fpu_op_a`, `fpu_op_b`  out  32  to FPU `op_A_in`/`op_B_in`; stable for the whole operation.
- `fpu_reset_n`  out  1  to FPU `reset` (active-low).
- `fpu_data`  in  32  from FPU `data_out`.
- `fpu_status`  in  4  from FPU `status_out`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE. All outputs are registered.
- **IDLE**
  - `fpu_reset_n`=0, so the FPU is held in reset.
  - If any `req` is high, select a winner (see Configuration) and latch its operands into `fpu_op_a`/`fpu_op_b`.
  - Pulse `ack` for the winner, record the owner, set `busy`=1, go to LAUNCH.
- **LAUNCH** (1 cycle): `fpu_reset_n`=1 at exit, load the counter with `WAIT_CYCLES-1`, go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - On the counter reaching 0, go to CAPTURE.
  - The FPU free-runs and repeats passes on the same operands. The first pass after FPU reset may be wrong; later passes are correct and identical, so the budget covers ≥2 passes.
- **CAPTURE**
  - `result`<=`fpu_data`, `status`<=`fpu_status`.
  - Pulse `done` for the owner.
  - `busy`<=0, `fpu_reset_n`<=0, update the priority pointer, go to IDLE.
- A `req` still high after its ack is treated as a new request at the next IDLE.
- Requests arriving in LAUNCH, WAIT or CAPTURE are neither acked nor dropped; they are evaluated at the next IDLE.
- When both requests arrive in the same IDLE cycle, exactly one ack is issued. The loser keeps its `req` high and is served next.

## Timing
- Reset values: `ack*`=0, `done*`=0, `result`=0, `status`=0, `busy`=0, `fpu_op_*`=0, `fpu_reset_n`=0, state=IDLE, priority pointer=client 0.
- Request sampled at edge k gives `ack`/`busy` high after edge k; `ack` low after k+1.
- `fpu_reset_n` rises after edge k+1, so the FPU sees edges k+2 … k+`WAIT_CYCLES`+1.
- `done`, `result` and `status` update at edge k+`WAIT_CYCLES`+2, and `busy` falls at the same edge.
- Earliest next ack is at edge k+`WAIT_CYCLES`+3. Throughput is one operation per `WAIT_CYCLES`+3 cycles.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately, and no `done` is issued.
  - The owner must re-request.
  - The FPU is held in reset via `fpu_reset_n`=0.

## Configuration
- `FPU_ARB_RR_EN` defined: round-robin.
  - The pointer selects the preferred client on a tie.
  - After every CAPTURE the pointer moves to the client that was not served.
- `FPU_ARB_RR_EN` undefined: fixed priority, client 0 always wins ties. No pointer register exists.

## Test plan
- **Single request:** after reset, `req0` with `op_a0`=0x02000000, `op_b0`=0x02000000 → `ack0` 1 cycle later; `done0` exactly `WAIT_CYCLES`+2 cycles after `ack0`; `result`=0x04000000, `status`=0001. `done1`/`ack1` never pulse.
- **Cancellation to zero:** `req1` with 0x02000000 and 0x82000000 → `done1`, `result`=0x00000000, `status`=0001.
- **Tie, round-robin:** `req0` and `req1` high together, held after ack, three rounds. With `FPU_ARB_RR_EN`: acks 0,1,0. Without it: acks 0,0,0.
- **Request during busy:** `req1` raised mid-WAIT of client 0 → no `ack1` until one cycle after `done0`. `fpu_op_*` stay unchanged through client 0's operation.
- **Reset mid-WAIT:** `reset` pulsed 20 cycles into WAIT → all outputs 0 at once, no `done`. After release, a new `req0` completes normally with correct `result`.
- **Operand stability:** `op_a0` is changed after `ack0` → `fpu_op_a` and the final `result` reflect the value latched at the ack.
